// File: rtl/scan_driver_dimmed.sv
// Four-digit multiplexed 7-segment scanner with tear-free frame loading, PWM dimming and per-digit blanking.
// Outputs are registered one cycle behind the scan counters; there is no backpressure, and loads are always accepted.
module scan_driver_dimmed #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sseg_in,
    input  logic        load,
    input  logic [2:0]  brightness,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  anode,
    output logic [7:0]  sseg,
    output logic        frame_done
);

    localparam int SUB_DIV = REFRESH_DIV / 8;
    localparam int SW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    // The 0..REFRESH_DIV-1 prescaler is held as {phase, sub_cnt}, so phase = prescaler / SUB_DIV needs no divider.
    logic [SW-1:0] sub_cnt;
    logic [2:0]    phase;
    logic [1:0]    digit;

    logic [31:0] staging;
    logic [31:0] display;
    logic        pending;
    logic [2:0]  sh_bright;
    logic [3:0]  sh_blank;

    logic       sub_end;
    logic       slot_end;
    logic       boundary;
    logic       lit;
    logic [7:0] cur_byte;

    assign sub_end  = (sub_cnt == SW'(SUB_DIV - 1));
    assign slot_end = sub_end && (phase == 3'd7);
    assign boundary = slot_end && (digit == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt <= '0;
            phase   <= 3'd0;
            digit   <= 2'd3;
        end else if (sub_end) begin
            sub_cnt <= '0;
            phase   <= phase + 3'd1;
            if (phase == 3'd7)
                digit <= digit - 2'd1;
        end else begin
            sub_cnt <= sub_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging   <= 32'hFFFF_FFFF;
            display   <= 32'hFFFF_FFFF;
            pending   <= 1'b0;
            sh_bright <= 3'd7;
            sh_blank  <= 4'b0000;
        end else begin
            if (load)
                staging <= sseg_in;
            if (boundary) begin
                sh_bright <= brightness;
                sh_blank  <= blank_mask;
                pending   <= 1'b0;
                // A load landing on the boundary bypasses staging so it is not held back a whole frame.
                if (load)
                    display <= sseg_in;
                else if (pending)
                    display <= staging;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign cur_byte = display[{digit, 3'b000} +: 8];
    assign lit      = (phase <= sh_bright) && !sh_blank[digit];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode      <= 4'b1111;
            sseg       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            anode      <= lit ? ~(4'b0001 << digit) : 4'b1111;
            sseg       <= lit ? cur_byte : 8'hFF;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_scan_driver_dimmed.sv
// Directed bench for scan_driver_dimmed at REFRESH_DIV = 16 (16-cycle slots, 64-cycle frames).
module tb_scan_driver_dimmed;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sseg_in = 32'h0;
    logic        load = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  anode;
    logic [7:0]  sseg;
    logic        frame_done;

    scan_driver_dimmed #(.REFRESH_DIV(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sseg_in    (sseg_in),
        .load       (load),
        .brightness (brightness),
        .blank_mask (blank_mask),
        .anode      (anode),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k = -1;
    int fd_bad = 0;
    int onehot_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // k = index of the last clock edge since reset release; outputs then reflect scan state k.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!rst) begin
                k++;
                if (frame_done !== ((k % 64) == 63)) fd_bad++;
                if ($countones(~anode) > 1) onehot_bad++;
            end
        end
    endtask

    task automatic step_to(input int target);
        if (target > k) step(target - k);
    endtask

    task automatic check_at(input string tag, input int target, input logic [3:0] exp_an, input logic [7:0] exp_sg);
        step_to(target);
        chk({tag, "_an"}, anode, exp_an);
        chk({tag, "_sg"}, sseg, exp_sg);
    endtask

    logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] sg_tab [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    int cnt;

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_an", anode, 4'b1111);
        chk("rst_sg", sseg, 8'hFF);
        chk("rst_fd", frame_done, 1'b0);
        step(2);
        rst = 1'b0;
        k = -1;

        // Scan starts at digit 3 showing the reset frame (all dark segments, full brightness).
        check_at("start", 0, 4'b0111, 8'hFF);

        step_to(2);
        load = 1'b1;
        sseg_in = 32'hC0F9A4B0;
        step(1);
        load = 1'b0;
        sseg_in = 32'h0;

        check_at("old_frame", 62, 4'b1110, 8'hFF);
        chk("fd_before", frame_done, 1'b0);
        step_to(63);
        chk("fd_pulse", frame_done, 1'b1);

        for (int d = 0; d < 4; d++) begin
            step(1);
            chk("slot_an", anode, an_tab[d]);
            chk("slot_sg", sseg, sg_tab[d]);
            cnt = 1;
            repeat (15) begin
                step(1);
                if (anode == an_tab[d] && sseg == sg_tab[d]) cnt++;
            end
            chk("slot_len", cnt, 16);
        end

        // Brightness 0 takes effect at the frame starting at 192: phase 0 only, 2 of 16 cycles.
        brightness = 3'd0;
        step_to(191);
        cnt = 0;
        repeat (16) begin
            step(1);
            if (anode == 4'b0111) cnt++;
        end
        chk("dim0_cnt", cnt, 2);
        brightness = 3'd3;
        check_at("dim_mid", 210, 4'b1111, 8'hFF);
        step_to(255);
        cnt = 0;
        repeat (16) begin
            step(1);
            if (anode == 4'b0111) cnt++;
        end
        chk("dim3_cnt", cnt, 8);

        // Two loads in one frame: only the later value should reach the display.
        load = 1'b1;
        sseg_in = 32'h11223344;
        step(1);
        load = 1'b0;
        step_to(285);
        load = 1'b1;
        sseg_in = 32'h55667788;
        step(1);
        load = 1'b0;
        sseg_in = 32'h0;
        check_at("no_tear", 288, 4'b1101, 8'hA4);
        check_at("last_d3", 320, 4'b0111, 8'h55);
        check_at("last_d2", 336, 4'b1011, 8'h66);
        check_at("last_d1", 352, 4'b1101, 8'h77);
        check_at("last_d0", 368, 4'b1110, 8'h88);

        // Load exactly on the boundary cycle (state 383).
        step_to(382);
        load = 1'b1;
        sseg_in = 32'h9ABCDEF0;
        step(1);
        load = 1'b0;
        sseg_in = 32'h0;
        check_at("bnd_d3", 384, 4'b0111, 8'h9A);
        check_at("bnd_d2", 400, 4'b1011, 8'hBC);
        check_at("bnd_d1", 416, 4'b1101, 8'hDE);
        check_at("bnd_d0", 432, 4'b1110, 8'hF0);

        blank_mask = 4'b0101;
        check_at("blank_mid", 433, 4'b1110, 8'hF0);
        check_at("blank_d3", 448, 4'b0111, 8'h9A);
        check_at("blank_d2", 464, 4'b1111, 8'hFF);
        check_at("blank_d1", 480, 4'b1101, 8'hDE);
        check_at("blank_d0", 496, 4'b1111, 8'hFF);

        // Asynchronous reset mid-slot while a load is pending.
        check_at("pre_rst", 512, 4'b0111, 8'h9A);
        load = 1'b1;
        sseg_in = 32'h12345678;
        step(1);
        load = 1'b0;
        chk("lit_rst_an", anode, 4'b0111);
        #2 rst = 1'b1;
        #1;
        chk("async_an", anode, 4'b1111);
        chk("async_sg", sseg, 8'hFF);
        chk("async_fd", frame_done, 1'b0);
        step(3);
        rst = 1'b0;
        k = -1;
        check_at("restart", 0, 4'b0111, 8'hFF);
        step_to(63);
        chk("restart_fd", frame_done, 1'b1);
        check_at("discard", 64, 4'b0111, 8'hFF);
        step_to(100);

        chk("fd_period", fd_bad, 0);
        chk("onehot", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_driver_dimmed.md
SCAN_DRIVER_DIMMED -- requirements
Module: scan_driver_dimmed

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter SUB_DIV, default REFRESH_DIV/8, cycles per brightness phase; derived, not overridden.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sseg_in  input  32  frame of four segment bytes, [31:24] = leftmost digit (anode[3]) down to [7:0] = anode[0]; active-low segments, bit 7 = dp.
REQ-006 load  input  1  one-cycle strobe; captures sseg_in into the staging register.
REQ-007 brightness  input  3  on-time level: 0 = 1/8 duty, 7 = full duty.
REQ-008 blank_mask  input  4  bit i = 1 forces digit i dark.
REQ-009 anode  output  4  active-low digit enables, registered.
REQ-010 sseg  output  8  active-low segment drive, registered.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; slot_end = (prescaler == REFRESH_DIV-1).
REQ-013 Phase = prescaler / SUB_DIV (0..7).
REQ-014 Digit index SHALL scan 3,2,1,0,3,... and advance on slot_end.
REQ-015 Frame boundary = slot_end while digit index == 0.
REQ-016 load SHALL write sseg_in into staging and set pending, in the same cycle.
REQ-017 On a frame boundary with pending set, display register <= staging; pending cleared.
REQ-018 load coinciding with a frame boundary: display register <= sseg_in directly, staging <= sseg_in, pending stays clear.
REQ-019 load during a frame SHALL NOT change the displayed frame before the next boundary (no tearing); a second load before the boundary overwrites staging (last wins).
REQ-020 brightness and blank_mask SHALL be sampled into shadow registers on every frame boundary only.
REQ-021 Digit i lit when phase <= shadow_brightness and shadow_blank[i] == 0; then anode = one-hot-low on bit i, sseg = display byte i.
REQ-022 Digit not lit: anode = 4'b1111, sseg = 8'hFF.
REQ-023 Outputs SHALL reflect counter/index state with exactly one cycle of register latency.
REQ-024 frame_done SHALL assert the cycle after a frame boundary, for one cycle; period = 4*REFRESH_DIV cycles.
REQ-025 At most one anode bit SHALL ever be low.

Reset
REQ-026 rst asserted SHALL immediately force anode = 4'b1111, sseg = 8'hFF, frame_done = 0, independent of clk.
REQ-027 Reset state: prescaler 0, digit index 3, staging and display 32'hFFFFFFFF, pending 0, shadow_brightness 7, shadow_blank 4'b0000.
REQ-028 Reset mid-frame SHALL discard staging/pending; scanning restarts at digit 3, prescaler 0, on first clk after deassertion.

Verification (REFRESH_DIV = 16, SUB_DIV = 2)
REQ-029 Reset release, then load with sseg_in = 32'hC0F9A4B0 in cycle 3 -> display changes at first boundary (cycle 64); following frame shows anode 0111/C0, 1011/F9, 1101/A4, 1110/B0, each 16 cycles.
REQ-030 brightness = 0 -> each digit anode low for 2 of 16 cycles per slot (phase 0 only); brightness = 3 -> 8 of 16.
REQ-031 load of value A mid-frame, then load of B in same frame -> only B displayed after the boundary; A never appears.
REQ-032 load exactly on the boundary cycle -> new value shown from the next frame's digit 3; pending reads 0.
REQ-033 blank_mask = 4'b0101 changed mid-frame -> takes effect next frame; digits 2 and 0 then anode 1111, sseg FF; frame_done pulses every 64 cycles throughout.
REQ-034 rst asserted asynchronously mid-slot -> anode 1111 and sseg FF the same simulation time step, before the next clk edge.
